// File: rtl/partition_sweep_checker_pkg.sv
// Shared types and helpers for the partition sweep checker.
// The TRACE state exists only when PSC_MISMATCH_TRACE_EN is defined.
package psc_pkg;

    localparam int DEF_NUM_IN  = 7;
    localparam int DEF_NUM_OUT = 4;
    localparam int DEF_SETTLE  = 1;

    localparam int NUM_VEC  = 2 ** DEF_NUM_IN;
    localparam int HAM_W    = DEF_NUM_IN + $clog2(DEF_NUM_OUT + 1);
    localparam int ERR_W    = DEF_NUM_IN + DEF_NUM_OUT;
    localparam int SETTLE_W = 4;
    localparam int POP_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
`ifdef PSC_MISMATCH_TRACE_EN
        S_TRACE,
`endif
        S_FINISH
    } state_t;

    function automatic logic [5:0] popcount(input logic [POP_W-1:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + 6'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/partition_sweep_checker_err_calc.sv
// Per-vector error terms: absolute difference, Hamming distance and mismatch flag.
module psc_err_calc
    import psc_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic [NUM_OUT-1:0]               po_exact,
    input  logic [NUM_OUT-1:0]               po_approx,
    output logic [NUM_OUT-1:0]               d,
    output logic [$clog2(NUM_OUT+1)-1:0]     h,
    output logic                             mismatch
);

    localparam int DHW = $clog2(NUM_OUT + 1);

    logic [NUM_OUT:0] raw;

    // One extra bit so the sign survives; the magnitude always fits NUM_OUT bits.
    assign raw      = {1'b0, po_exact} - {1'b0, po_approx};
    assign d        = raw[NUM_OUT] ? NUM_OUT'(-raw) : raw[NUM_OUT-1:0];
    assign h        = DHW'(popcount(POP_W'(po_exact ^ po_approx)));
    assign mismatch = (po_exact != po_approx);

endmodule

// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep-and-compare engine for one approximated partition.
// Optional mismatch trace port is enabled by defining PSC_MISMATCH_TRACE_EN.
module partition_sweep_checker
    import psc_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic [NUM_IN-1:0]                     pi,
    input  logic [NUM_OUT-1:0]                    po_exact,
    input  logic [NUM_OUT-1:0]                    po_approx,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_IN:0]                       mismatch_cnt,
    output logic [NUM_IN+$clog2(NUM_OUT+1)-1:0]   hamming_sum,
    output logic [NUM_IN+NUM_OUT-1:0]             err_sum,
    output logic [NUM_OUT-1:0]                    max_abs_err
`ifdef PSC_MISMATCH_TRACE_EN
    ,
    output logic                                  trace_valid,
    output logic [NUM_IN+2*NUM_OUT-1:0]           trace_vec,
    input  logic                                  trace_ready
`endif
);

    localparam int MW  = NUM_IN + 1;
    localparam int HW  = NUM_IN + $clog2(NUM_OUT + 1);
    localparam int EW  = NUM_IN + NUM_OUT;
    localparam int DHW = $clog2(NUM_OUT + 1);

    state_t                state;
    logic [NUM_IN-1:0]     cnt;
    logic [SETTLE_W-1:0]   settle_cnt;

    logic [NUM_OUT-1:0]    d;
    logic [DHW-1:0]        h;
    logic                  mis;
    logic                  trace_hit;

    psc_err_calc #(.NUM_OUT(NUM_OUT)) u_err_calc (
        .po_exact  (po_exact),
        .po_approx (po_approx),
        .d         (d),
        .h         (h),
        .mismatch  (mis)
    );

`ifdef PSC_MISMATCH_TRACE_EN
    assign trace_hit = mis;
`else
    assign trace_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            settle_cnt   <= '0;
            pi           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            hamming_sum  <= '0;
            err_sum      <= '0;
            max_abs_err  <= '0;
`ifdef PSC_MISMATCH_TRACE_EN
            trace_valid  <= 1'b0;
            trace_vec    <= '0;
`endif
        end else begin
            // NOTE: every register here uses <=, so all branches read pre-edge values.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_DRIVE;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        mismatch_cnt <= '0;
                        hamming_sum  <= '0;
                        err_sum      <= '0;
                        max_abs_err  <= '0;
                    end
                end
                S_DRIVE: begin
                    pi <= cnt;
                    if (SETTLE == 0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= SETTLE_W'(SETTLE - 1);
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_SAMPLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    mismatch_cnt <= mismatch_cnt + MW'(mis);
                    hamming_sum  <= hamming_sum + HW'(h);
                    err_sum      <= err_sum + EW'(d);
                    if (d > max_abs_err) max_abs_err <= d;
                    // A traced mismatch defers the advance/finish decision to TRACE.
                    if (trace_hit) begin
`ifdef PSC_MISMATCH_TRACE_EN
                        trace_valid <= 1'b1;
                        trace_vec   <= {pi, po_exact, po_approx};
                        state       <= S_TRACE;
`endif
                    end else if (&cnt) begin
                        state <= S_FINISH;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_DRIVE;
                    end
                end
`ifdef PSC_MISMATCH_TRACE_EN
                S_TRACE: begin
                    if (trace_ready) begin
                        trace_valid <= 1'b0;
                        if (&cnt) begin
                            state <= S_FINISH;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_DRIVE;
                        end
                    end
                end
`endif
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Directed, table-driven bench for partition_sweep_checker with a small partition model.
module tb_partition_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  pi;
    logic [3:0]  po_exact;
    logic [3:0]  po_approx;
    logic        busy;
    logic        done;
    logic [7:0]  mismatch_cnt;
    logic [9:0]  hamming_sum;
    logic [10:0] err_sum;
    logic [3:0]  max_abs_err;

    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;

    always #5 clk = ~clk;

`ifdef PSC_MISMATCH_TRACE_EN
    logic        trace_valid;
    logic [15:0] trace_vec;
    logic        trace_ready = 1'b1;
    int          beats      = 0;
    int          trace_errs = 0;

    always @(posedge clk) begin
        if (trace_valid && trace_ready) begin
            beats++;
            if (trace_vec !== {pi, po_exact, po_approx}) trace_errs++;
        end
    end
`endif

    // Exact partition model plus selectable approximate variants.
    always_comb begin
        po_exact = 4'(pi[2:0]) + 4'(pi[5:3]) + 4'(pi[6]);
        case (mode)
            1:       po_approx = po_exact ^ 4'b0001;
            2:       po_approx = 4'b0000;
            3:       po_approx = ~po_exact;
            default: po_approx = po_exact;
        endcase
    end

    partition_sweep_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pi           (pi),
        .po_exact     (po_exact),
        .po_approx    (po_approx),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .hamming_sum  (hamming_sum),
        .err_sum      (err_sum),
        .max_abs_err  (max_abs_err)
`ifdef PSC_MISMATCH_TRACE_EN
        ,
        .trace_valid  (trace_valid),
        .trace_vec    (trace_vec),
        .trace_ready  (trace_ready)
`endif
    );

    typedef struct {
        int mode;
        int mis;
        int ham;
        int err;
        int mx;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_metrics(input vec_t v);
        check("mismatch_cnt", mismatch_cnt, v.mis);
        check("hamming_sum", hamming_sum, v.ham);
        check("err_sum", err_sum, v.err);
        check("max_abs_err", max_abs_err, v.mx);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pi"}, pi, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_metric_bits"}, {mismatch_cnt, hamming_sum, err_sum, max_abs_err}, 0);
    endtask

    // Runs one sweep from IDLE; optionally pulses start while busy.
    task automatic run_sweep(input bit spam, input int exp_lat);
        int         lat;
        int         dones;
        int         exp_pi;
        int         pi_errs;
        logic [6:0] prev;
        lat     = 0;
        dones   = 0;
        pi_errs = 0;
        prev    = pi;
        exp_pi  = (pi == 7'd0) ? 1 : 0;
`ifdef PSC_MISMATCH_TRACE_EN
        beats      = 0;
        trace_errs = 0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            start = spam && (c % 7 == 0) && (c < 300);
            if (c == 1) check("busy_rise", busy, 1);
            if (pi != prev) begin
                if (int'(pi) != exp_pi) pi_errs++;
                exp_pi++;
                prev = pi;
            end
            if (done) begin
                dones++;
                if (lat == 0) lat = c;
            end
            if (lat != 0 && c >= lat + 3) break;
        end
        start = 1'b0;
        check("done_latency", lat, exp_lat);
        check("done_pulses", dones, 1);
        check("pi_sequence_errs", pi_errs, 0);
        check("pi_values_seen", exp_pi, 128);
        check("busy_after_done", busy, 0);
        check("pi_final", pi, 127);
    endtask

    function automatic int lat_for(input vec_t v);
`ifdef PSC_MISMATCH_TRACE_EN
        return 385 + v.mis;
`else
        return 385;
`endif
    endfunction

    initial begin
        tbl[0] = '{mode: 0, mis: 0,   ham: 0,   err: 0,   mx: 0};
        tbl[1] = '{mode: 1, mis: 128, ham: 128, err: 128, mx: 1};
        tbl[2] = '{mode: 2, mis: 127, ham: 256, err: 960, mx: 15};
        tbl[3] = '{mode: 3, mis: 128, ham: 512, err: 688, mx: 15};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep(1'b0, lat_for(tbl[i]));
            check_metrics(tbl[i]);
`ifdef PSC_MISMATCH_TRACE_EN
            check("trace_beats", beats, tbl[i].mis);
            check("trace_content_errs", trace_errs, 0);
`endif
        end

        // Reset 100 cycles into a sweep, then a clean sweep must give full totals.
        begin
            int dones_in_reset;
            dones_in_reset = 0;
            mode  = 3;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (100) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check_zero_outputs("mid_reset");
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                if (done) dones_in_reset++;
            end
            check("done_during_reset", dones_in_reset, 0);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check_zero_outputs("after_reset");
            mode = 1;
            run_sweep(1'b0, lat_for(tbl[1]));
            check_metrics(tbl[1]);
        end

        // start pulsed repeatedly while busy must be ignored.
        mode = 2;
        run_sweep(1'b1, lat_for(tbl[2]));
        check_metrics(tbl[2]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
